// File: rtl/cavlc_pkg.sv
// Shared CAVLC definitions.
// Keeps field widths and the statistics-stage state encoding in one place so
// that the coeff_token encoder and the level/run encoders agree on them.
package cavlc_pkg;

    localparam int unsigned COEFF_W_DEF = 12;             // default coefficient width
    localparam int unsigned MAX_COEFF   = 16;             // largest block (luma 4x4)
    localparam int unsigned IDX_W       = $clog2(MAX_COEFF);      // scan index 0..15
    localparam int unsigned PTR_W       = $clog2(MAX_COEFF + 1);  // LIFO fill 0..16
    localparam int unsigned TC_W        = 5;              // TotalCoeff 0..16
    localparam int unsigned TZ_W        = 4;              // TotalZeros 0..15
    localparam int unsigned T1_W        = 2;              // TrailOneNum 0..3
    localparam int unsigned NC_W        = 3;              // NC class
    localparam int unsigned RUN_W       = 4;              // run_before 0..15

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_e;

endpackage

// File: rtl/cavlc_level_lifo.sv
// Level/run stack for one block.
// Ports:
//   clk        clock
//   clr_i      synchronous clear of the fill pointer (entries discarded)
//   push_i     push push_data_i (ignored when full)
//   pop_i      drop the top entry (ignored when empty)
//   push_data_i {level, run_before}
//   top_o      top entry, 0 when empty
//   empty_o    no entries held
module cavlc_level_lifo
    import cavlc_pkg::*;
#(
    parameter int unsigned W = COEFF_W_DEF + RUN_W
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] push_data_i,
    output logic [W-1:0] top_o,
    output logic         empty_o
);

    logic [W-1:0]     mem_q [MAX_COEFF];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] top_ptr;

    assign empty_o = (ptr_q == '0);
    assign top_ptr = ptr_q - PTR_W'(1);
    assign top_o   = empty_o ? '0 : mem_q[top_ptr[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            ptr_q <= '0;
        end else if (push_i && (ptr_q != PTR_W'(MAX_COEFF))) begin
            mem_q[ptr_q[IDX_W-1:0]] <= push_data_i;
            ptr_q                   <= ptr_q + PTR_W'(1);
        end else if (pop_i && !empty_o) begin
            ptr_q <= top_ptr;
        end
    end

endmodule

// File: rtl/cavlc_coeff_stats.sv
// CAVLC block statistics stage.
// Collects one block of zig-zag coefficients (one per in_valid/in_ready
// handshake), then presents TotalCoeff, TrailOneNum, TotalZeros, the
// trailing-ones signs and NC until out_valid/out_ready. Nonzero levels and
// their run_before are stacked so they pop out highest-frequency first.
// Ports:
//   clk, rst_n           clock; rst_n is a synchronous ACTIVE-HIGH reset
//   coeff_in, nc_in      coefficient input, NC class (taken at index 0)
//   in_valid, in_ready   input handshake
//   out_valid, out_ready statistics handshake; out_ready releases the block
//   TotalCoeff, TrailOneNum, TotalZeros, t1_signs, NC  block statistics
//   lvl_pop, lvl_data, lvl_run, lvl_empty              level/run stack access
module cavlc_coeff_stats
    import cavlc_pkg::*;
#(
    parameter int unsigned COEFF_W   = COEFF_W_DEF,
    parameter int unsigned NUM_COEFF = MAX_COEFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COEFF_W-1:0] coeff_in,
    input  logic [NC_W-1:0]    nc_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TC_W-1:0]    TotalCoeff,
    output logic [T1_W-1:0]    TrailOneNum,
    output logic [TZ_W-1:0]    TotalZeros,
    output logic [2:0]         t1_signs,
    output logic [NC_W-1:0]    NC,
    input  logic               lvl_pop,
    output logic [COEFF_W-1:0] lvl_data,
    output logic [RUN_W-1:0]   lvl_run,
    output logic               lvl_empty
);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] last_nz_q;
    logic [RUN_W-1:0] zrun_q;
    logic [TC_W-1:0]  tc_q;
    logic [T1_W-1:0]  t1run_q;
    logic [2:0]       t1s_q;
    logic [NC_W-1:0]  nc_q;

    logic accept, release_blk, is_zero, is_one;
    logic [TC_W-1:0] tz_full;
    logic [COEFF_W+RUN_W-1:0] lifo_top;

    assign in_ready    = (state_q == COLLECT) && !rst_n;
    assign out_valid   = (state_q == OUTPUT);
    assign accept      = in_valid && in_ready;
    assign release_blk = out_valid && out_ready;
    assign is_zero     = (coeff_in == '0);
    assign is_one      = (coeff_in == COEFF_W'(1)) || (coeff_in == '1);

    // last_nz+1-TotalCoeff fits TZ_W whenever TotalCoeff>0
    assign tz_full     = TC_W'(last_nz_q) + TC_W'(1) - tc_q;

    assign TotalCoeff  = tc_q;
    assign TrailOneNum = t1run_q;
    assign TotalZeros  = (tc_q == '0) ? '0 : tz_full[TZ_W-1:0];
    assign t1_signs    = t1s_q & ((3'b001 << t1run_q) - 3'b001);
    assign NC          = nc_q;
    assign lvl_data    = lifo_top[COEFF_W+RUN_W-1:RUN_W];
    assign lvl_run     = lifo_top[RUN_W-1:0];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= COLLECT;
            idx_q     <= '0;
            last_nz_q <= '0;
            zrun_q    <= '0;
            tc_q      <= '0;
            t1run_q   <= '0;
            t1s_q     <= '0;
            nc_q      <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        idx_q <= idx_q + IDX_W'(1);
                        if (idx_q == '0) nc_q <= nc_in;
                        if (is_zero) begin
                            zrun_q <= zrun_q + RUN_W'(1);
                        end else begin
                            zrun_q    <= '0;
                            tc_q      <= tc_q + TC_W'(1);
                            last_nz_q <= idx_q;
                        end
                        if (is_one) begin
                            t1run_q <= (t1run_q == 2'd3) ? 2'd3 : t1run_q + 2'd1;
                            t1s_q   <= {t1s_q[1:0], coeff_in[COEFF_W-1]};
                        end else if (!is_zero) begin
                            t1run_q <= '0;
                            t1s_q   <= '0;
                        end
                        if (idx_q == IDX_W'(NUM_COEFF - 1)) state_q <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        state_q   <= COLLECT;
                        idx_q     <= '0;
                        last_nz_q <= '0;
                        zrun_q    <= '0;
                        tc_q      <= '0;
                        t1run_q   <= '0;
                        t1s_q     <= '0;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    cavlc_level_lifo #(
        .W (COEFF_W + RUN_W)
    ) u_lifo (
        .clk         (clk),
        .clr_i       (rst_n || release_blk),
        .push_i      (accept && !is_zero),
        .pop_i       (lvl_pop && out_valid),
        .push_data_i ({coeff_in, zrun_q}),
        .top_o       (lifo_top),
        .empty_o     (lvl_empty)
    );

endmodule

// File: tb/tb_cavlc_coeff_stats.sv
module tb_cavlc_coeff_stats;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [11:0] coeff_in = '0;
    logic [2:0]  nc_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  TotalCoeff;
    logic [1:0]  TrailOneNum;
    logic [3:0]  TotalZeros;
    logic [2:0]  t1_signs;
    logic [2:0]  NC;
    logic        lvl_pop = 1'b0;
    logic [11:0] lvl_data;
    logic [3:0]  lvl_run;
    logic        lvl_empty;

    int checks = 0;
    int errors = 0;
    logic [11:0] blk [16];

    always #5 clk = ~clk;

    cavlc_coeff_stats #(
        .COEFF_W   (12),
        .NUM_COEFF (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coeff_in    (coeff_in),
        .nc_in       (nc_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .TotalCoeff  (TotalCoeff),
        .TrailOneNum (TrailOneNum),
        .TotalZeros  (TotalZeros),
        .t1_signs    (t1_signs),
        .NC          (NC),
        .lvl_pop     (lvl_pop),
        .lvl_data    (lvl_data),
        .lvl_run     (lvl_run),
        .lvl_empty   (lvl_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one coefficient; returns after the accepting edge (+1).
    task automatic send_coeff(input logic [11:0] c, input logic [2:0] nc);
        int n = 0;
        coeff_in = c;
        nc_in    = nc;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Send blk[], check statistics and the level/run stack against a model
    // built straight from the block contents, then release the block.
    task automatic run_block(input logic [2:0] nc, input bit pop_in_collect,
                             input bit hold, input bit partial);
        int tc = 0, last = -1, tz = 0, t1 = 0, npop;
        bit stop = 0;
        logic [2:0] sg = '0;
        logic [11:0] exp_lv [$];
        int exp_rn [$];

        for (int i = 0; i < 16; i++)
            if (blk[i] != 0) begin tc++; last = i; end
        for (int i = 0; i < last; i++)
            if (blk[i] == 0) tz++;
        for (int i = last; i >= 0; i--) begin
            if (!stop && blk[i] != 0) begin
                if ((blk[i] == 12'h001 || blk[i] == 12'hFFF) && t1 < 3) begin
                    sg[t1] = blk[i][11];
                    t1++;
                end else begin
                    stop = 1;
                end
            end
        end
        for (int i = last; i >= 0; i--) begin
            if (blk[i] != 0) begin
                int z = 0;
                int j = i - 1;
                while (j >= 0 && blk[j] == 0) begin z++; j--; end
                exp_lv.push_back(blk[i]);
                exp_rn.push_back(z);
            end
        end

        lvl_pop = pop_in_collect;
        for (int i = 0; i < 16; i++) send_coeff(blk[i], (i == 0) ? nc : ~nc);
        lvl_pop = 1'b0;

        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("TotalCoeff", 32'(TotalCoeff), 32'(tc));
        chk("TrailOneNum", 32'(TrailOneNum), 32'(t1));
        chk("t1_signs", 32'(t1_signs), 32'(sg));
        chk("TotalZeros", 32'(TotalZeros), 32'(tz));
        chk("NC", 32'(NC), 32'(nc));

        if (hold) begin
            in_valid = 1'b1;
            coeff_in = 12'h005;
            repeat (5) begin
                @(negedge clk);
                chk("hold_in_ready", 32'(in_ready), 32'd0);
                chk("hold_out_valid", 32'(out_valid), 32'd1);
                chk("hold_TotalCoeff", 32'(TotalCoeff), 32'(tc));
                chk("hold_TotalZeros", 32'(TotalZeros), 32'(tz));
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end

        npop = partial ? exp_lv.size() / 2 : exp_lv.size();
        for (int k = 0; k < npop; k++) begin
            @(negedge clk);
            chk("lvl_empty_busy", 32'(lvl_empty), 32'd0);
            chk("lvl_data", 32'(lvl_data), 32'(exp_lv[k]));
            chk("lvl_run", 32'(lvl_run), 32'(exp_rn[k]));
            lvl_pop = 1'b1;
            @(posedge clk);
            #1;
            lvl_pop = 1'b0;
        end
        @(negedge clk);
        if (!partial) begin
            chk("lvl_empty_end", 32'(lvl_empty), 32'd1);
            // pop on an empty stack must be ignored
            lvl_pop = 1'b1;
            @(posedge clk);
            #1;
            lvl_pop = 1'b0;
            chk("lvl_empty_extra_pop", 32'(lvl_empty), 32'd1);
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_lvl_empty", 32'(lvl_empty), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_TotalCoeff"}, 32'(TotalCoeff), 32'd0);
        chk({tag, "_TrailOneNum"}, 32'(TrailOneNum), 32'd0);
        chk({tag, "_TotalZeros"}, 32'(TotalZeros), 32'd0);
        chk({tag, "_t1_signs"}, 32'(t1_signs), 32'd0);
        chk({tag, "_NC"}, 32'(NC), 32'd0);
        chk({tag, "_lvl_empty"}, 32'(lvl_empty), 32'd1);
        chk({tag, "_lvl_data"}, 32'(lvl_data), 32'd0);
        chk({tag, "_lvl_run"}, 32'(lvl_run), 32'd0);
    endtask

    initial begin
        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_lvl_empty", 32'(lvl_empty), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("post_rst");
        @(posedge clk);
        #1;

        // directed block from the plan
        foreach (blk[i]) blk[i] = '0;
        blk[1] = 12'h003; blk[2] = 12'hFFF; blk[5] = 12'hFFF;
        blk[6] = 12'h001; blk[8] = 12'h001;
        run_block(3'd1, 1'b0, 1'b0, 1'b0);

        // all zeros
        foreach (blk[i]) blk[i] = '0;
        run_block(3'd2, 1'b0, 1'b0, 1'b0);

        // all +1
        foreach (blk[i]) blk[i] = 12'h001;
        run_block(3'd3, 1'b0, 1'b0, 1'b0);

        // index 14 = 1, index 15 = 2, with backpressure
        foreach (blk[i]) blk[i] = '0;
        blk[14] = 12'h001; blk[15] = 12'h002;
        run_block(3'd4, 1'b0, 1'b1, 1'b0);

        // independent block after backpressure
        foreach (blk[i]) blk[i] = '0;
        blk[0] = 12'hFFE; blk[3] = 12'hFFF;
        run_block(3'd5, 1'b0, 1'b0, 1'b0);

        // reset in the middle of a block
        for (int i = 0; i < 7; i++) send_coeff(12'(i + 2), 3'd6);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("midrst");
        @(posedge clk);
        #1;
        foreach (blk[i]) blk[i] = '0;
        blk[4] = 12'hFFF; blk[9] = 12'h007; blk[10] = 12'h001;
        run_block(3'd7, 1'b0, 1'b0, 1'b0);

        // randomized blocks
        for (int b = 0; b < 24; b++) begin
            for (int i = 0; i < 16; i++) begin
                int unsigned r = $urandom_range(9);
                if (r < 5)      blk[i] = '0;
                else if (r < 7) blk[i] = 12'h001;
                else if (r < 8) blk[i] = 12'hFFF;
                else            blk[i] = 12'(int'($urandom_range(100)) - 50);
            end
            run_block(3'($urandom_range(7)), b[0], (b % 5) == 0, b[1]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cavlc_coeff_stats.md
Name: cavlc_coeff_stats

Overview:
Upstream stage of the CAVLC coeff_token encoder. It accepts one 4x4 block of quantised coefficients in zig-zag order, one coefficient per handshake. It then produces the statistics the coeff_token, trailing-ones, total_zeros and run_before encoders need: TotalCoeff, TrailOneNum, TotalZeros, the trailing-ones signs and NC. It also buffers the nonzero levels with their run_before values in a LIFO, so downstream stages can read them in reverse (highest-frequency-first) order.

Parameters:
COEFF_W, 12, signed coefficient width
NUM_COEFF, 16, coefficients per block (16 luma 4x4, 15 AC, 4 chroma DC); legal range 4..16

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-high despite the _n suffix (name kept for codebase consistency)
coeff_in  in  COEFF_W  signed coefficient, zig-zag order
nc_in  in  3  NC class for this block; sampled with the first accepted coefficient
in_valid  in  1  coeff_in valid
in_ready  out  1  block can accept a coefficient
out_valid  out  1  statistics valid
out_ready  in  1  downstream consumed statistics; releases the block
TotalCoeff  out  5  nonzero count, 0..16
TrailOneNum  out  2  trailing ±1 count, capped at 3
TotalZeros  out  4  zeros before the last nonzero, 0..15
t1_signs  out  3  bit0 = sign of the last nonzero trailing one, bit1 = next lower, ...; 1 = negative; unused bits 0
NC  out  3  latched nc_in
lvl_pop  in  1  pop one LIFO entry
lvl_data  out  COEFF_W  top-of-LIFO level
lvl_run  out  4  zeros immediately below that level in scan order (run_before)
lvl_empty  out  1  LIFO empty

Behaviour:
- Reset state: COLLECT; in_ready=0 during reset, 1 on the first cycle after; all other outputs 0; lvl_empty=1.
- State COLLECT:
  - in_ready=1, out_valid=0.
  - Coefficient accepted when in_valid&&in_ready.
  - Index counter idx runs 0..NUM_COEFF-1.
- Per accepted coefficient c:
  - c==0: zrun++ (4-bit).
  - c!=0: push {c, zrun} to the LIFO; zrun←0; TotalCoeff++; last_nz←idx.
  - c==±1: t1run←min(t1run+1,3); t1_signs←{t1_signs[1:0], sign} (shift-left, new sign enters bit0).
  - |c|>1: t1run←0; t1_signs←0.
- Sampling: nc_in is latched when idx==0.
- Transition to OUTPUT: on acceptance at idx==NUM_COEFF-1, enter OUTPUT the next cycle.
  - out_valid=1 there, i.e. latency is 1 cycle after the last accept.
  - in_ready drops combinationally in OUTPUT.
- Output values:
  - TrailOneNum=t1run.
  - t1_signs masked to TrailOneNum bits.
  - TotalZeros = TotalCoeff==0 ? 0 : last_nz+1-TotalCoeff.
- State OUTPUT:
  - All statistic outputs stable until out_valid&&out_ready.
  - lvl_pop allowed; it pops one entry per cycle.
  - lvl_data/lvl_run show the top entry combinationally.
  - A pop while lvl_empty is ignored.
  - A pop in COLLECT is ignored.
- Release: out_valid&&out_ready → COLLECT next cycle. Counters, zrun, t1 state and LIFO pointer are cleared; unpopped entries are discarded. A pop in the same cycle as release is a don't-care.
- Back-to-back: a new block may be accepted on the first COLLECT cycle after release, giving a 1-cycle bubble minimum.
- Reset mid-block: everything is discarded; the next accepted coefficient is idx 0.
- LIFO: depth 16; it cannot overflow (at most NUM_COEFF pushes per block).

Decomposition:
- Shared package cavlc_pkg: COEFF_W default, MAX_COEFF=16, state encoding {COLLECT, OUTPUT}, field widths for TotalCoeff/TotalZeros/TrailOneNum/NC, so coeff_token_enc and the level/run encoders agree.
- One sub-module, cavlc_level_lifo: 16 x (COEFF_W+4) register stack with push, pop, clear, empty and top outputs.

Test Plan:
- Block 0,3,-1,0,0,-1,1,0,1,0×7 (nc_in=1):
  - Statistics → TotalCoeff=5, TrailOneNum=3, t1_signs=3'b100, TotalZeros=4, NC=1.
  - Pops yield (1,1), (1,0), (-1,2), (-1,0), (3,1), then lvl_empty=1.
- All 16 zeros → TotalCoeff=0, TrailOneNum=0, TotalZeros=0, t1_signs=0, lvl_empty=1.
- All 16 = +1 → TotalCoeff=16, TrailOneNum=3, t1_signs=0, TotalZeros=0; 16 pops each (1,0).
- Index 14=1, index 15=2, rest 0 → TotalCoeff=2, TrailOneNum=0, TotalZeros=14; pops (2,0), (1,14).
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 and outputs stable. Raise out_ready → in_ready=1 the next cycle; the following block's stats are independent of the first.
- Assert rst_n after 7 accepted coefficients → outputs zero. A full fresh block then gives correct stats, with no leakage from the aborted one.
